// File: rtl/ic_sweep_pkg.sv
// Shared types and helpers for the invertibility-condition sweep checkers.
package ic_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int IC_W = 4;

    // Mismatch counter must hold 2^(2W) without wrapping.
    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

    function automatic logic [IC_W-1:0] vec_s(input logic [2*IC_W-1:0] v);
        return v[IC_W-1:0];
    endfunction

    function automatic logic [IC_W-1:0] vec_t(input logic [2*IC_W-1:0] v);
        return v[2*IC_W-1:IC_W];
    endfunction

endpackage

// File: rtl/ic_ashr_uge_step.sv
// One term of the ashr/uge invertibility condition: (s >>> k) >=u t.
module ic_ashr_uge_step
    import ic_sweep_pkg::*;
#(
    parameter int W  = IC_W,
    parameter int KW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  s,
    input  logic [W-1:0]  t,
    input  logic [KW-1:0] k,
    output logic          ge
);

    logic [W-1:0] sh_s;

    assign sh_s = W'($signed(s) >>> k);
    assign ge   = (sh_s >= t);

endmodule

// File: rtl/ic_ashr_uge_sweep_checker.sv
// Exhaustive (s, t) sweep driving a Skolem netlist and checking its output
// against the golden ashr/uge invertibility condition.
module ic_ashr_uge_sweep_checker
    import ic_sweep_pkg::*;
#(
    parameter int W     = IC_W,
    parameter int CNT_W = cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   vec_o,
    input  logic             skolem_i,
    output logic             golden_o,
    output logic             cmp_valid,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [2*W-1:0]   first_fail_vec,
    output logic             first_fail_valid,
    output logic             pass
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    state_t        state_r;
    logic [KW-1:0] k_r;
    logic          acc_r;
    logic          step_ge_s;
    logic          mismatch_s;

    ic_ashr_uge_step #(.W(W), .KW(KW)) u_step (
        .s  (vec_o[W-1:0]),
        .t  (vec_o[2*W-1:W]),
        .k  (k_r),
        .ge (step_ge_s)
    );

    assign mismatch_s = (skolem_i != golden_o);

    // Sweep FSM: vec_o is the vector counter itself, so it holds for a whole vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            k_r              <= '0;
            acc_r            <= 1'b0;
            vec_o            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            golden_o         <= 1'b0;
            cmp_valid        <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r          <= EVAL;
                        k_r              <= '0;
                        acc_r            <= 1'b0;
                        vec_o            <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        mismatch_cnt     <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                EVAL: begin
                    acc_r <= acc_r | step_ge_s;
                    if (k_r == K_LAST) begin
                        state_r   <= CMP;
                        golden_o  <= acc_r | step_ge_s;
                        cmp_valid <= 1'b1;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                CMP: begin
                    cmp_valid <= 1'b0;
                    golden_o  <= 1'b0;
                    if (mismatch_s) begin
                        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec_o;
                        end
                    end
                    if (vec_o == {(2*W){1'b1}}) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= ~(first_fail_valid | mismatch_s);
                    end else begin
                        state_r <= EVAL;
                        vec_o   <= vec_o + (2*W)'(1);
                        k_r     <= '0;
                        acc_r   <= 1'b0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_ashr_uge_sweep_checker.sv
// Randomised self-checking bench for ic_ashr_uge_sweep_checker (W=4).
module tb_ic_ashr_uge_sweep_checker;

    localparam int W     = 4;
    localparam int NV    = 256;
    localparam int SWEEP = 1280;
    localparam int CNT_W = 2 * W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   vec_o;
    logic             skolem_i;
    logic             golden_o;
    logic             cmp_valid;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [2*W-1:0]   first_fail_vec;
    logic             first_fail_valid;
    logic             pass;

    int          checks = 0;
    int          errors = 0;
    int          mode   = 0;
    logic [NV-1:0] fmask = '0;
    int          pulses = 0;
    int          gbad   = 0;
    int          exp_vec = 0;

    ic_ashr_uge_sweep_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .vec_o            (vec_o),
        .skolem_i         (skolem_i),
        .golden_o         (golden_o),
        .cmp_valid        (cmp_valid),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid),
        .pass             (pass)
    );

    always #5 clk = ~clk;

    // Reference: try every shift amount, including ones beyond W.
    function automatic logic ref_ic(input logic [7:0] v);
        logic signed [3:0] s;
        logic [3:0]        t;
        logic [3:0]        r;
        s = v[3:0];
        t = v[7:4];
        for (int x = 0; x < 8; x++) begin
            r = s >>> x;
            if (r >= t) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb begin
        case (mode)
            0:       skolem_i = golden_o;
            1:       skolem_i = 1'b0;
            2:       skolem_i = 1'b1;
            default: skolem_i = ref_ic(vec_o) ^ fmask[vec_o];
        endcase
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cmp_valid === 1'b1) begin
                pulses = pulses + 1;
                if (golden_o !== ref_ic(vec_o)) gbad = gbad + 1;
                if (vec_o !== exp_vec[7:0]) gbad = gbad + 1;
                exp_vec = exp_vec + 1;
            end else if (golden_o !== 1'b0) begin
                gbad = gbad + 1;
            end
        end
    end

    task automatic do_start();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        start = 1'b1;
        pulses = 0;
        gbad = 0;
        exp_vec = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int repulse_at, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == repulse_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #1;
        checks++;
        if ({busy, done, vec_o, golden_o, cmp_valid, mismatch_cnt, first_fail_vec, first_fail_valid, pass} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b vec=%h cnt=%0d pass=%b, required all 0", busy, done, vec_o, mismatch_cnt, pass);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_golden_tied();
        int cyc;
        mode = 0;
        do_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL tied_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        wait_done(-1, cyc);
        checks++; if (cyc != SWEEP) begin errors++; $display("FAIL tied_latency: %0d cycles, required %0d", cyc, SWEEP); end
        checks++; if (pulses != NV) begin errors++; $display("FAIL tied_pulses: %0d, required %0d", pulses, NV); end
        checks++; if (gbad != 0) begin errors++; $display("FAIL tied_golden: %0d bad compares, required 0", gbad); end
        checks++; if (mismatch_cnt !== 0 || first_fail_valid !== 1'b0) begin errors++; $display("FAIL tied_result: cnt=%0d ffv=%b, required 0 0", mismatch_cnt, first_fail_valid); end
        checks++; if (pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tied_pass: pass=%b busy=%b, required 1 0", pass, busy); end
    endtask

    task automatic test_stuck(input int m, input int exp_cnt, input logic [7:0] exp_first);
        int cyc;
        mode = m;
        do_start();
        wait_done(-1, cyc);
        checks++; if (cyc != SWEEP) begin errors++; $display("FAIL stuck%0d_latency: %0d, required %0d", m - 1, cyc, SWEEP); end
        checks++; if (mismatch_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL stuck%0d_count: %0d, required %0d", m - 1, mismatch_cnt, exp_cnt); end
        checks++; if (first_fail_valid !== 1'b1 || first_fail_vec !== exp_first) begin errors++; $display("FAIL stuck%0d_first: ffv=%b vec=%h, required 1 %h", m - 1, first_fail_valid, first_fail_vec, exp_first); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL stuck%0d_pass: pass=%b done=%b, required 0 1", m - 1, pass, done); end
    endtask

    task automatic test_spot();
        int cyc = 0;
        int seen = 0;
        mode = 0;
        do_start();
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cmp_valid === 1'b1 && vec_o === 8'h76) begin
                seen++;
                checks++;
                if (golden_o !== 1'b0) begin errors++; $display("FAIL spot_76: golden=%b, required 0", golden_o); end
            end
            if (cmp_valid === 1'b1 && vec_o === 8'hF8) begin
                seen++;
                checks++;
                if (golden_o !== 1'b1) begin errors++; $display("FAIL spot_f8: golden=%b, required 1", golden_o); end
            end
        end
        checks++;
        if (seen != 2) begin errors++; $display("FAIL spot_seen: %0d spot compares, required 2", seen); end
    endtask

    task automatic test_random_faults(input int density);
        int cyc;
        int exp_cnt = 0;
        int exp_first = -1;
        for (int i = 0; i < NV; i++) begin
            fmask[i] = ($urandom_range(0, density - 1) == 0);
            if (fmask[i]) begin
                exp_cnt++;
                if (exp_first < 0) exp_first = i;
            end
        end
        mode = 3;
        do_start();
        wait_done(-1, cyc);
        checks++; if (mismatch_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rand_count: %0d, required %0d", mismatch_cnt, exp_cnt); end
        checks++;
        if (exp_cnt == 0) begin
            if (first_fail_valid !== 1'b0 || pass !== 1'b1) begin errors++; $display("FAIL rand_first: ffv=%b pass=%b, required 0 1", first_fail_valid, pass); end
        end else if (first_fail_valid !== 1'b1 || first_fail_vec !== 8'(exp_first) || pass !== 1'b0) begin
            errors++;
            $display("FAIL rand_first: ffv=%b vec=%h pass=%b, required 1 %h 0", first_fail_valid, first_fail_vec, pass, 8'(exp_first));
        end
        checks++; if (gbad != 0) begin errors++; $display("FAIL rand_golden: %0d bad compares, required 0", gbad); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        mode = 0;
        do_start();
        wait_done(100, cyc);
        checks++; if (cyc != SWEEP) begin errors++; $display("FAIL restart_ignored: %0d cycles, required %0d", cyc, SWEEP); end
        checks++; if (pulses != NV) begin errors++; $display("FAIL restart_pulses: %0d, required %0d", pulses, NV); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mode = 1;
        do_start();
        repeat (500) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, vec_o, golden_o, cmp_valid, mismatch_cnt, first_fail_vec, first_fail_valid, pass} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b vec=%h cnt=%0d ffv=%b, required all 0", busy, vec_o, mismatch_cnt, first_fail_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || vec_o !== 8'h00) begin errors++; $display("FAIL midreset_idle: busy=%b vec=%h, required 0 00", busy, vec_o); end
        mode = 0;
        do_start();
        wait_done(-1, cyc);
        checks++; if (cyc != SWEEP || pulses != NV) begin errors++; $display("FAIL midreset_sweep: %0d cycles %0d pulses, required %0d %0d", cyc, pulses, SWEEP, NV); end
        checks++; if (mismatch_cnt !== 0 || pass !== 1'b1) begin errors++; $display("FAIL midreset_result: cnt=%0d pass=%b, required 0 1", mismatch_cnt, pass); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        test_stuck(1, 164, 8'h00);
        mode = 0;
        do_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || mismatch_cnt !== 0 || first_fail_valid !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear: done=%b busy=%b cnt=%0d ffv=%b pass=%b, required 0 1 0 0 0", done, busy, mismatch_cnt, first_fail_valid, pass);
        end
        wait_done(-1, cyc);
        checks++; if (cyc != SWEEP) begin errors++; $display("FAIL b2b_latency: %0d, required %0d", cyc, SWEEP); end
        checks++; if (mismatch_cnt !== 0 || first_fail_valid !== 1'b0 || pass !== 1'b1) begin errors++; $display("FAIL b2b_result: cnt=%0d ffv=%b pass=%b, required 0 0 1", mismatch_cnt, first_fail_valid, pass); end
    endtask

    initial begin
        test_reset();
        test_golden_tied();
        test_stuck(1, 164, 8'h00);
        test_stuck(2, 92, 8'h10);
        test_spot();
        test_random_faults(8);
        test_random_faults(40);
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic_ashr_uge_sweep_checker.md
Name: ic_ashr_uge_sweep_checker

Overview:
- Sequential stimulus/checker stage that sits directly upstream of a synthesized Skolem-function netlist for the bvuge/bvashr invertibility condition.
- Exhaustively sweeps every (s, t) operand pair and drives it onto the netlist inputs.
- Computes the golden invertibility condition internally: exists x such that (s >>a x) >=u t.
- Samples the netlist's 1-bit output, compares it against the golden value, and reports the mismatch count plus the first failing vector.

Parameters:
- W, 4, operand bit-width; the netlist input vector is 2W bits (8 for W=4).
- CNT_W, 2*W+1, mismatch counter width; holds 2^(2W) without overflow.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle sweep request
- busy  out  1  sweep in progress
- done  out  1  sweep complete; sticky until next accepted start
- vec_o  out  2W  netlist inputs: [W-1:0]=s, [2W-1:W]=t
- skolem_i  in  1  netlist output for vec_o (combinational path through netlist)
- golden_o  out  1  golden IC value for vec_o; valid when cmp_valid=1
- cmp_valid  out  1  one-cycle pulse on each compare
- mismatch_cnt  out  CNT_W  number of vectors with skolem_i != golden
- first_fail_vec  out  2W  vec_o of the first mismatch
- first_fail_valid  out  1  at least one mismatch recorded
- pass  out  1  done & ~first_fail_valid

Behaviour:
- Reset values: every output is 0; state=IDLE; vector counter=0; shift counter k=0; accumulator acc=0.
- Reset is asynchronous. Asserting rst_n low mid-sweep aborts immediately. After release the block sits in IDLE with all counters cleared and no partial results retained.
- IDLE:
  - start=1 -> EVAL.
  - On entry: vec=0, k=0, acc=0, mismatch_cnt=0, first_fail_valid=0, first_fail_vec=0, done=0, busy=1.
- EVAL, one cycle per k in 0..W-1:
  - acc <= acc | ((s >>> k) >=u t), where >>> is arithmetic (sign-filling) shift of the W-bit s.
  - k=W-1 -> CMP.
  - Shift amounts >= W give the same result as k=W-1, so iterating 0..W-1 covers every x.
  - No early exit: timing is fixed.
- CMP, one cycle:
  - golden_o = final acc (including the k=W-1 term); cmp_valid=1.
  - If skolem_i != golden_o: mismatch_cnt += 1. If first_fail_valid=0, also capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec is all-ones -> DONE. Otherwise vec += 1, k=0, acc=0, -> EVAL.
- DONE:
  - busy=0, done=1. mismatch_cnt, first_fail_vec, first_fail_valid and pass hold.
  - start=1 -> restart exactly as from IDLE, clearing all results.
- vec_o equals the vector counter and is stable through all EVAL and CMP cycles of a vector, giving the netlist W cycles to settle. skolem_i is sampled only in CMP.
- start while busy=1 is ignored.
- Sweep order: s is the low half and increments fastest.
- Per-vector latency is W+1 cycles. Total is 2^(2W)*(W+1) cycles from start acceptance to done: 1280 for W=4.
- mismatch_cnt is sized so it never wraps; no saturation logic.
- golden_o is 0 outside CMP.
- Golden arithmetic uses unsigned W-bit compare only; no width extension.

Decomposition:
- Shared package ic_sweep_pkg:
  - state enum {IDLE, EVAL, CMP, DONE};
  - default W;
  - CNT_W derivation function;
  - vector field slice helpers for s and t.
- One sub-module: ic_ashr_uge_step, combinational, (s, t, k) -> ((s >>> k) >=u t). It is reusable by sibling sweepers for other shift/compare pairs.

Test Plan (W=4):
- skolem_i tied to golden_o, start pulse -> done at cycle 1280 after start, mismatch_cnt=0, first_fail_valid=0, pass=1, exactly 256 cmp_valid pulses.
- skolem_i stuck at 0 -> mismatch_cnt=164, first_fail_vec=8'h00, pass=0.
  - 164 = 128 vectors with negative s (all t succeed via k=3) + 36 with t<=s for s=0..7.
- skolem_i stuck at 1 -> mismatch_cnt=92, first_fail_vec=8'h10 (s=0, t=1), pass=0.
- Spot checks with a golden-tied DUT, checked at the CMP pulse:
  - vec_o=8'h76 (s=0110, t=0111) -> golden_o=0.
  - vec_o=8'hF8 (s=1000, t=1111) -> golden_o=1.
- Control and reset:
  - start re-pulsed at cycle 100 -> ignored; done still at cycle 1280.
  - rst_n low at cycle 500 -> all outputs 0 within the same cycle.
  - New start after release -> full clean 1280-cycle sweep.
- Back-to-back runs:
  - Stuck-at-0 sweep, then start in DONE with skolem_i tied to golden_o.
  - Second run reports mismatch_cnt=0, first_fail_valid=0, pass=1.
